keypad_entry_ctrl: RTL and testbench

Debounce and entry controller that sits between the keypad row scanner and the dual seven-segment display driver. It qualifies each candidate keypress reported by the scanner, holds it for a programmable debounce interval, and decodes it to a hex digit. It then shifts the digit into a two-digit history and locks out further entries until the key is released cleanly. Each physical press yields exactly one entry, regardless of hold time, bounce, or extra keys pressed while held.

---
 rtl/keypad_entry_ctrl.sv | 160 ++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_entry_ctrl: debounces scanner keypresses and keeps a two-digit |
// | hex entry history. Each physical press produces one entry. Rev 1.0    |
// +----------------------------------------------------------------------+
module keypad_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] row,
    input  logic [3:0] col_sync,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       key_strobe,
    output logic       busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] c_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_ACCEPT   = 3'd2,
        S_HELD     = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cand_row;
    logic [3:0]    r_cand_col;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_digit_new;
    logic [3:0]    r_digit_old;
    logic          r_strobe;

    logic          w_present;
    logic          w_start;
    logic          w_cnt_done;
    logic [3:0]    w_decoded;

    function automatic logic f_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Keypad legend, row-major: index = {row_idx, col_idx}
    function automatic logic [3:0] f_decode(input logic [3:0] r, input logic [3:0] c);
        logic [1:0] ri;
        logic [1:0] ci;
        logic [3:0] d;
        ri = 2'd0;
        ci = 2'd0;
        case (r)
            4'b0010: ri = 2'd1;
            4'b0100: ri = 2'd2;
            4'b1000: ri = 2'd3;
            default: ri = 2'd0;
        endcase
        case (c)
            4'b0010: ci = 2'd1;
            4'b0100: ci = 2'd2;
            4'b1000: ci = 2'd3;
            default: ci = 2'd0;
        endcase
        case ({ri, ci})
            4'h0:    d = 4'h1;
            4'h1:    d = 4'h2;
            4'h2:    d = 4'h3;
            4'h3:    d = 4'hA;
            4'h4:    d = 4'h4;
            4'h5:    d = 4'h5;
            4'h6:    d = 4'h6;
            4'h7:    d = 4'hB;
            4'h8:    d = 4'h7;
            4'h9:    d = 4'h8;
            4'hA:    d = 4'h9;
            4'hB:    d = 4'hC;
            4'hC:    d = 4'hE;
            4'hD:    d = 4'h0;
            4'hE:    d = 4'hF;
            default: d = 4'hD;
        endcase
        return d;
    endfunction

    assign w_present  = (row == r_cand_row) && ((col_sync & r_cand_col) != 4'd0);
    assign w_start    = key_valid && f_onehot(row) && f_onehot(col_sync);
    assign w_cnt_done = (r_cnt == c_CNT_MAX);
    assign w_decoded  = f_decode(r_cand_row, r_cand_col);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cand_row  <= 4'd0;
            r_cand_col  <= 4'd0;
            r_cnt       <= '0;
            r_digit_new <= 4'd0;
            r_digit_old <= 4'd0;
            r_strobe    <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cand_row <= row;
                        r_cand_col <= col_sync;
                        r_cnt      <= '0;
                        r_state    <= S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (!w_present) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_cnt_done) begin
                        r_digit_old <= r_digit_new;
                        r_digit_new <= w_decoded;
                        r_strobe    <= 1'b1;
                        r_state     <= S_ACCEPT;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_ACCEPT: begin
                    r_state <= S_HELD;
                end
                S_HELD: begin
                    if (!w_present) begin
                        r_cnt   <= '0;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // A returning key here is release bounce, not a new press
                    if (w_present) begin
                        r_cnt   <= '0;
                        r_state <= S_HELD;
                    end else if (w_cnt_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign digit_new  = r_digit_new;
    assign digit_old  = r_digit_old;
    assign key_strobe = r_strobe;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_keypad_entry_ctrl: directed, table-driven and randomized checks of |
// | keypad_entry_ctrl against a run-length behavioural model. Rev 1.0     |
// +----------------------------------------------------------------------+
module tb_keypad_entry_ctrl;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] row = 4'd0;
    logic [3:0] col_sync = 4'd0;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_strobe;
    logic       busy;

    int n_checks = 0;
    int n_fail = 0;

    keypad_entry_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .row        (row),
        .col_sync   (col_sync),
        .digit_new  (digit_new),
        .digit_old  (digit_old),
        .key_strobe (key_strobe),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        logic [3:0] exp_new;
        logic [3:0] exp_old;
    } vec_t;
    vec_t tbl[16];

    logic [3:0] kmap[16];

    // Reference model: run lengths of key presence since the candidate was taken
    bit         m_cand, m_acc, m_skip, m_strobe;
    logic [3:0] m_row, m_col, m_new, m_old;
    int         m_hi, m_lo;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sb(input string name, input logic s, input logic b);
        chk(name, {14'd0, key_strobe, busy}, {14'd0, s, b});
    endtask

    task automatic chk_dig(input string name, input logic [3:0] n, input logic [3:0] o);
        chk(name, {8'd0, digit_new, digit_old}, {8'd0, n, o});
    endtask

    task automatic do_reset;
        reset = 1'b0;
        key_valid = 1'b0;
        row = 4'd0;
        col_sync = 4'd0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic press_check(input string name, input logic [3:0] r, input logic [3:0] c,
                               input logic [3:0] en, input logic [3:0] eo);
        key_valid = 1'b1;
        row = r;
        col_sync = c;
        tick();
        chk_sb({name, " enter"}, 1'b0, 1'b1);
        key_valid = 1'b0;
        repeat (N - 1) begin
            tick();
            chk_sb({name, " debounce"}, 1'b0, 1'b1);
        end
        tick();
        chk_sb({name, " strobe"}, 1'b1, 1'b1);
        chk_dig({name, " digits"}, en, eo);
        tick();
        chk_sb({name, " strobe end"}, 1'b0, 1'b1);
    endtask

    task automatic release_check(input string name);
        row = 4'd0;
        col_sync = 4'd0;
        repeat (N) begin
            tick();
            chk_sb({name, " releasing"}, 1'b0, 1'b1);
        end
        tick();
        chk_sb({name, " idle"}, 1'b0, 1'b0);
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic bit is_onehot(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) if (v[i]) n++;
        return n == 1;
    endfunction

    task model_step(input logic kv, input logic [3:0] r, input logic [3:0] c);
        bit present;
        present = m_cand && (r == m_row) && ((c & m_col) != 4'd0);
        m_strobe = 1'b0;
        if (!m_cand) begin
            if (kv && is_onehot(r) && is_onehot(c)) begin
                m_cand = 1'b1;
                m_acc = 1'b0;
                m_row = r;
                m_col = c;
                m_hi = 0;
            end
        end else if (!m_acc) begin
            if (!present) m_cand = 1'b0;
            else begin
                m_hi++;
                if (m_hi == N) begin
                    m_acc = 1'b1;
                    m_skip = 1'b1;
                    m_lo = 0;
                    m_strobe = 1'b1;
                    m_old = m_new;
                    m_new = kmap[idx_of(m_row) * 4 + idx_of(m_col)];
                end
            end
        end else if (m_skip) begin
            m_skip = 1'b0;
        end else if (present) begin
            m_lo = 0;
        end else begin
            m_lo++;
            if (m_lo == N + 1) m_cand = 1'b0;
        end
    endtask

    initial begin
        int p_r, p_c, timer;
        bit down;
        kmap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        tbl[0]  = '{4'b0001, 4'b0001, 4'h1, 4'h0};
        tbl[1]  = '{4'b0001, 4'b0010, 4'h2, 4'h1};
        tbl[2]  = '{4'b0001, 4'b0100, 4'h3, 4'h2};
        tbl[3]  = '{4'b0001, 4'b1000, 4'hA, 4'h3};
        tbl[4]  = '{4'b0010, 4'b0001, 4'h4, 4'hA};
        tbl[5]  = '{4'b0010, 4'b0010, 4'h5, 4'h4};
        tbl[6]  = '{4'b0010, 4'b0100, 4'h6, 4'h5};
        tbl[7]  = '{4'b0010, 4'b1000, 4'hB, 4'h6};
        tbl[8]  = '{4'b0100, 4'b0001, 4'h7, 4'hB};
        tbl[9]  = '{4'b0100, 4'b0010, 4'h8, 4'h7};
        tbl[10] = '{4'b0100, 4'b0100, 4'h9, 4'h8};
        tbl[11] = '{4'b0100, 4'b1000, 4'hC, 4'h9};
        tbl[12] = '{4'b1000, 4'b0001, 4'hE, 4'hC};
        tbl[13] = '{4'b1000, 4'b0010, 4'h0, 4'hE};
        tbl[14] = '{4'b1000, 4'b0100, 4'hF, 4'h0};
        tbl[15] = '{4'b1000, 4'b1000, 4'hD, 4'hF};

        // Reset values
        #2;
        chk("reset outputs", {6'd0, digit_new, digit_old, key_strobe, busy}, 16'd0);
        do_reset();
        chk("after reset", {6'd0, digit_new, digit_old, key_strobe, busy}, 16'd0);

        // Clean press of '6', release
        press_check("s1", 4'b0010, 4'b0100, 4'h6, 4'h0);
        repeat (15) begin
            tick();
            chk_sb("s1 held", 1'b0, 1'b1);
        end
        release_check("s1");

        // Two-digit history
        press_check("s2a", 4'b0010, 4'b0010, 4'h5, 4'h6);
        release_check("s2a");
        press_check("s2b", 4'b1000, 4'b1000, 4'hD, 4'h5);
        release_check("s2b");

        // Bounce during debounce aborts the candidate
        key_valid = 1'b1;
        row = 4'b0100;
        col_sync = 4'b0100;
        tick();
        chk_sb("s3 enter", 1'b0, 1'b1);
        key_valid = 1'b0;
        repeat (2) begin
            tick();
            chk_sb("s3 bounce hi", 1'b0, 1'b1);
        end
        col_sync = 4'b0000;
        tick();
        chk_sb("s3 abort", 1'b0, 1'b0);
        chk_dig("s3 digits kept", 4'hD, 4'h5);
        press_check("s3", 4'b0100, 4'b0100, 4'h9, 4'hD);
        release_check("s3");

        // Release bounce produces no extra entry
        press_check("s4", 4'b0001, 4'b0100, 4'h3, 4'h9);
        repeat (3) begin
            col_sync = 4'b0000;
            repeat (2) begin
                tick();
                chk_sb("s4 drop", 1'b0, 1'b1);
            end
            col_sync = 4'b0100;
            tick();
            chk_sb("s4 return", 1'b0, 1'b1);
        end
        release_check("s4");
        chk_dig("s4 digits", 4'h3, 4'h9);

        // Malformed key_valid in IDLE
        key_valid = 1'b1;
        row = 4'b0010;
        col_sync = 4'b0110;
        tick();
        chk_sb("s5 two cols", 1'b0, 1'b0);
        row = 4'b0011;
        col_sync = 4'b0100;
        tick();
        chk_sb("s5 two rows", 1'b0, 1'b0);
        key_valid = 1'b0;
        row = 4'b0000;
        col_sync = 4'b0000;
        tick();
        // Second key while held
        press_check("s5", 4'b0001, 4'b0001, 4'h1, 4'h3);
        col_sync = 4'b0011;
        repeat (8) begin
            key_valid = ~key_valid;
            tick();
            chk_sb("s5 multikey", 1'b0, 1'b1);
        end
        key_valid = 1'b0;
        chk_dig("s5 digits kept", 4'h1, 4'h3);
        release_check("s5");

        // Asynchronous reset in the middle of debounce
        key_valid = 1'b1;
        row = 4'b0100;
        col_sync = 4'b0001;
        tick();
        key_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("s6 async reset", {6'd0, digit_new, digit_old, key_strobe, busy}, 16'd0);
        #2;
        reset = 1'b1;
        repeat (8) begin
            tick();
            chk_sb("s6 aborted", 1'b0, 1'b0);
        end
        chk_dig("s6 digits", 4'h0, 4'h0);

        // Table: every key, chained history
        do_reset();
        for (int i = 0; i < 16; i++) begin
            press_check("table", tbl[i].row, tbl[i].col, tbl[i].exp_new, tbl[i].exp_old);
            release_check("table");
        end

        // Randomized presses with bounce and noise against the model
        do_reset();
        m_cand = 0; m_acc = 0; m_skip = 0; m_strobe = 0;
        m_row = 0; m_col = 0; m_new = 0; m_old = 0; m_hi = 0; m_lo = 0;
        p_r = 0; p_c = 0; timer = 0; down = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (timer == 0) begin
                down = !down;
                timer = down ? $urandom_range(1, 14) : $urandom_range(1, 10);
                if (down && $urandom_range(0, 2) == 0) begin
                    p_r = $urandom_range(0, 3);
                    p_c = $urandom_range(0, 3);
                end
            end else begin
                timer--;
            end
            row = 4'b0001 << p_r;
            if ($urandom_range(0, 15) == 0) row = 4'($urandom);
            col_sync = down ? (4'b0001 << p_c) : 4'b0000;
            if ($urandom_range(0, 15) == 0) col_sync = col_sync | 4'($urandom);
            key_valid = ($urandom_range(0, 3) == 0);
            model_step(key_valid, row, col_sync);
            tick();
            chk("random", {6'd0, key_strobe, busy, digit_new, digit_old},
                {6'd0, m_strobe, m_cand, m_new, m_old});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
